// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Width of the request timeout counter; TIMEOUT must fit (1..255).
    localparam int TIMER_W = 8;

    // Instruction addresses are word aligned: the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Loadable up-counter that times how long a memory request has waited.
// Latency: count updates one cycle after clr/ld/en; term is combinational.
// Backpressure: none; term flags the enabled cycle whose increment reaches TIMEOUT.
//
// Ports: clk, rst (async, active-high); clr clears, ld loads ld_val, en
// increments (priority clr > ld > en); term is high when en is set and the
// count is TIMEOUT-1, i.e. this cycle is the TIMEOUT-th waiting cycle.
module fetch_timer
    import inst_fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               ld,
    input  logic [TIMER_W-1:0] ld_val,
    input  logic               en,
    output logic               term
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = en && (count == LAST);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one imem read at a time, strobes the IR.
// Latency: fetch_en -> imem_req next cycle; imem_ack -> ir_wr next cycle (2 cycles minimum).
// Backpressure: waits indefinitely-bounded for imem_ack; after TIMEOUT waiting cycles it locks in ERR.
//
// Ports:
//   clk, rst (async, active-high)
//   fetch_en            fetch word at pc (only looked at in IDLE)
//   pc_ld, pc_ld_val    redirect the PC (low two bits forced to zero)
//   imem_req/imem_addr  registered read request, held until imem_ack
//   imem_ack/imem_rdata one-cycle read response
//   ir_wr/ir_data       one-cycle IR write strobe; ir_data held between strobes
//   pc_out, pc_plus4    current PC and PC+4 (wraps modulo 2^32)
//   busy, fetch_err     not IDLE; sticky request timeout
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        pc_ld,
    input  logic [31:0] pc_ld_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_wr,
    output logic [31:0] ir_data,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  redir_pc;   // redirect target captured while a request is in flight
    logic         flush;      // the in-flight request's data must be dropped
    logic         tmr_clr;
    logic         tmr_en;
    logic         tmr_term;

    // Timer restarts on every issued request and counts only cycles that
    // wait on memory; an ack cycle never counts toward the timeout.
    assign tmr_clr = (state == IDLE) && !pc_ld && fetch_en;
    assign tmr_en  = (state == REQ) && !imem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (tmr_en),
        .term   (tmr_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            redir_pc  <= '0;
            flush     <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir_wr     <= 1'b0;
            ir_data   <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_ld) begin
                        pc <= word_align(pc_ld_val);
                    end else if (fetch_en) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    // An issued request is never aborted: a redirect only
                    // marks the eventual response for disposal.
                    if (pc_ld) begin
                        redir_pc <= word_align(pc_ld_val);
                        flush    <= 1'b1;
                    end
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (flush || pc_ld) begin
                            // A redirect in the ack cycle itself is the newest
                            // target, so it takes precedence over redir_pc.
                            pc    <= pc_ld ? word_align(pc_ld_val) : redir_pc;
                            flush <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ir_data <= imem_rdata;
                            ir_wr   <= 1'b1;
                            pc      <= pc_plus4;
                            state   <= DONE;
                        end
                    end else if (tmr_term) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        flush     <= 1'b0;
                        state     <= ERR;
                    end
                end

                DONE: begin
                    ir_wr <= 1'b0;
                    state <= IDLE;
                    if (pc_ld) begin
                        pc <= word_align(pc_ld_val);
                    end
                end

                default: begin
                    // ERR holds everything until reset.
                    imem_req  <= 1'b0;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

    assign pc_out   = pc;
    assign pc_plus4 = pc + 32'd4;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: random fetches, redirects and memory latencies against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TMO    = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        pc_ld;
    logic [31:0] pc_ld_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_wr;
    logic [31:0] ir_data;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_err;

    inst_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .pc_ld      (pc_ld),
        .pc_ld_val  (pc_ld_val),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_wr      (ir_wr),
        .ir_data    (ir_data),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues: expected request addresses and expected IR writes.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_pc_q[$];

    logic [31:0] mpc;   // model PC

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        req_q;
        logic [31:0] cur_addr;
        logic [31:0] last_ir;
        req_q    = 1'b0;
        cur_addr = '0;
        last_ir  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_q   = 1'b0;
                last_ir = '0;
            end else begin
                if (imem_req && !req_q) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                        chk("req_addr", imem_addr, cur_addr);
                    end
                end else if (imem_req) begin
                    chk("req_addr_stable", imem_addr, cur_addr);
                end
                req_q = imem_req;
                if (ir_wr) begin
                    if (exp_data_q.size() == 0) begin
                        chk("unexpected_ir_wr", 32'd1, 32'd0);
                    end else begin
                        last_ir = exp_data_q.pop_front();
                        chk("ir_data", ir_data, last_ir);
                        chk("ir_wr_pc", pc_out, exp_pc_q.pop_front());
                    end
                end else begin
                    chk("ir_data_held", ir_data, last_ir);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_pc"}, pc_out, mpc);
        chk({tag, "_pc4"}, pc_plus4, mpc + 32'd4);
    endtask

    // One fetch: ack arrives d cycles after imem_req rises; pc_ld pulses in
    // every REQ cycle whose bit is set in rmask; done_ld redirects in DONE.
    task automatic do_fetch(input int d, input logic [15:0] rmask, input logic [31:0] rdata,
                            input logic done_ld, input logic [31:0] done_val);
        logic        flushed;
        logic [31:0] last_tgt;
        flushed  = 1'b0;
        last_tgt = '0;
        fetch_en = 1'b1;
        exp_addr_q.push_back(mpc);
        cyc();
        fetch_en = 1'b0;
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        chk("busy_req", {31'd0, busy}, 32'd1);
        for (int i = 0; i <= d; i++) begin
            pc_ld      = rmask[i];
            pc_ld_val  = $urandom;
            imem_ack   = (i == d);
            imem_rdata = (i == d) ? rdata : $urandom;
            fetch_en   = $urandom_range(0, 1);   // ignored outside IDLE
            if (rmask[i]) begin
                flushed  = 1'b1;
                last_tgt = pc_ld_val & 32'hFFFF_FFFC;
            end
            if (i == d && !flushed) begin
                exp_data_q.push_back(rdata);
                exp_pc_q.push_back(mpc + 32'd4);
            end
            cyc();
        end
        pc_ld    = 1'b0;
        imem_ack = 1'b0;
        fetch_en = 1'b0;
        if (flushed) begin
            mpc = last_tgt;
            chk("flush_no_wr", {31'd0, ir_wr}, 32'd0);
            idle_checks("flush");
        end else begin
            mpc = mpc + 32'd4;
            chk("ir_wr_lat", {31'd0, ir_wr}, 32'd1);
            chk("busy_done", {31'd0, busy}, 32'd1);
            pc_ld     = done_ld;
            pc_ld_val = done_val;
            fetch_en  = $urandom_range(0, 1);    // ignored in DONE
            cyc();
            pc_ld    = 1'b0;
            fetch_en = 1'b0;
            if (done_ld) mpc = done_val & 32'hFFFF_FFFC;
            chk("ir_wr_drop", {31'd0, ir_wr}, 32'd0);
            idle_checks("after_done");
        end
    endtask

    // Idle cycles with stray acks and redirects; a redirect may coincide with
    // fetch_en and must win.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack   = $urandom_range(0, 1);
            imem_rdata = $urandom;
            pc_ld      = ($urandom_range(0, 3) == 0);
            pc_ld_val  = $urandom;
            fetch_en   = pc_ld ? $urandom_range(0, 1) : 1'b0;
            cyc();
            if (pc_ld) mpc = pc_ld_val & 32'hFFFF_FFFC;
            imem_ack = 1'b0;
            pc_ld    = 1'b0;
            fetch_en = 1'b0;
            idle_checks("idle");
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_ld     = 1'b1;
        pc_ld_val = v;
        cyc();
        pc_ld = 1'b0;
        mpc   = v & 32'hFFFF_FFFC;
        idle_checks("set_pc");
    endtask

    initial begin : driver
        int          d;
        logic [15:0] m;
        rst        = 1'b1;
        fetch_en   = 1'b0;
        pc_ld      = 1'b0;
        pc_ld_val  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        mpc        = RST_PC;
        #3;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_ir_wr", {31'd0, ir_wr}, 32'd0);
        chk("rst_ir_data", ir_data, 32'd0);
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_pc4", pc_plus4, RST_PC + 32'd4);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Directed cases.
        do_fetch(0, 16'h0000, 32'h2408_0005, 1'b0, '0);   // minimum latency
        do_fetch(5, 16'h0000, 32'hDEAD_BEEF, 1'b0, '0);   // delayed ack
        begin
            // redirect to 0x4003 two cycles into the request
            pc_ld_val = 32'h0000_4003;
            fetch_en  = 1'b1;
            exp_addr_q.push_back(mpc);
            cyc();
            fetch_en = 1'b0;
            cyc();
            pc_ld = 1'b1;
            cyc();
            pc_ld = 1'b0;
            cyc();
            imem_ack   = 1'b1;
            imem_rdata = 32'h1111_2222;
            cyc();
            imem_ack = 1'b0;
            mpc      = 32'h0000_4000;
            chk("redir_no_wr", {31'd0, ir_wr}, 32'd0);
            idle_checks("redir");
        end
        do_fetch(1, 16'h0000, 32'h0000_0004, 1'b0, '0);   // addresses 0x4000
        do_fetch(3, 16'h0008, 32'h0BAD_F00D, 1'b0, '0);   // pc_ld coincides with ack
        do_fetch(4, 16'h0005, 32'h5555_AAAA, 1'b0, '0);   // two redirects, last wins
        do_fetch(TMO - 1, 16'h0000, 32'hCAFE_0001, 1'b1, 32'h0000_5006); // longest legal wait, DONE redirect
        set_pc(32'hFFFF_FFFF);
        do_fetch(2, 16'h0000, 32'h7777_0000, 1'b0, '0);   // pc wraps to 0
        chk("wrap_pc", pc_out, 32'h0000_0000);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(0, TMO - 1);
            m = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'((32'd1 << (d + 1)) - 1) : 16'h0000;
            do_fetch(d, m, $urandom, ($urandom_range(0, 3) == 0), $urandom);
            idle_gap($urandom_range(0, 3));
        end

        // Reset while a request is outstanding.
        fetch_en = 1'b1;
        exp_addr_q.push_back(mpc);
        cyc();
        fetch_en = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req", {31'd0, imem_req}, 32'd0);
        chk("rstreq_ir_wr", {31'd0, ir_wr}, 32'd0);
        chk("rstreq_ir_data", ir_data, 32'd0);
        chk("rstreq_pc", pc_out, RST_PC);
        #3 rst = 1'b0;
        mpc = RST_PC;
        cyc();
        idle_checks("post_rst");

        // Timeout: no ack for TMO cycles.
        fetch_en = 1'b1;
        exp_addr_q.push_back(mpc);
        cyc();
        fetch_en = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_req_high", {31'd0, imem_req}, 32'd1);
            cyc();
        end
        chk("tmo_req_drop", {31'd0, imem_req}, 32'd0);
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        chk("tmo_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            fetch_en   = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            cyc();
            chk("err_req", {31'd0, imem_req}, 32'd0);
            chk("err_sticky", {31'd0, fetch_err}, 32'd1);
            chk("err_busy", {31'd0, busy}, 32'd1);
            chk("err_pc", pc_out, mpc);
        end
        fetch_en = 1'b0;
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("err_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("err_rst_busy", {31'd0, busy}, 32'd0);
        #3 rst = 1'b0;
        mpc = RST_PC;
        cyc();
        do_fetch(2, 16'h0000, 32'h0123_4567, 1'b0, '0);   // recovery after reset

        cyc();
        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("data_q_empty", 32'(exp_data_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch controller for the multi-cycle CPU datapath. It owns the PC and runs a req/ack handshake with instruction memory. It returns each fetched word to the instruction register as a one-cycle write strobe (ir_wr) plus data, and is the producer side of the IR load interface. Control FSM requests fetches with fetch_en and redirects the PC with pc_ld (branch/jump).

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset (word aligned)
TIMEOUT, 15, max cycles imem_req may stay high without imem_ack before error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
fetch_en  in  1  request fetch of word at current PC; sampled only in IDLE
pc_ld  in  1  load PC with pc_ld_val (redirect)
pc_ld_val  in  32  redirect target; bits [1:0] ignored, forced 0
imem_req  out  1  memory read request, registered
imem_addr  out  32  read address, stable while imem_req=1
imem_ack  in  1  memory data valid; one-cycle pulse
imem_rdata  in  32  instruction word, valid when imem_ack=1
ir_wr  out  1  one-cycle IR write strobe
ir_data  out  32  fetched instruction, held until next ir_wr
pc_out  out  32  current PC
pc_plus4  out  32  pc_out+4, combinational
busy  out  1  state != IDLE
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, ir_wr=0, ir_data=0, fetch_err=0, timer=0, flush=0.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - pc_ld=1 → pc<=pc_ld_val&~3, stay IDLE. pc_ld has priority over fetch_en in the same cycle.
  - else fetch_en=1 → imem_req<=1, imem_addr<=pc, timer<=0, go REQ.
- REQ:
  - imem_req and imem_addr held stable until ack; no abort of an issued request.
  - imem_ack=1 with flush=0 → ir_data<=imem_rdata, ir_wr<=1, pc<=pc+4, imem_req<=0, go DONE.
  - imem_ack=1 with flush=1 → data discarded, no ir_wr, pc<=saved redirect target, flush<=0, imem_req<=0, go IDLE.
  - pc_ld=1 in REQ → save pc_ld_val&~3 into redirect register, flush<=1; last pc_ld wins. If pc_ld and imem_ack coincide, the ack is treated as flushed.
  - No ack → timer++. Timer reaching TIMEOUT without ack → imem_req<=0, fetch_err<=1, go ERR.
- DONE (one cycle): ir_wr=1; next cycle ir_wr=0, go IDLE. pc_ld in DONE overwrites the just-incremented pc. fetch_en ignored.
- ERR: absorbing state; imem_req=0, busy=1, fetch_err=1; exit only via rst. Late imem_ack ignored.
- Latency: fetch_en at cycle 0 → imem_req high at cycle 1; ack at cycle k≥1 → ir_wr high at cycle k+1. Minimum fetch_en-to-ir_wr latency is 2 cycles.
- Memory may ack in the first cycle imem_req is high. imem_ack while imem_req=0 is ignored.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- rst mid-REQ drops imem_req immediately; no ir_wr is produced.
- At most one outstanding request at any time.

Decomposition:
- Package inst_fetch_pkg: state enum (IDLE/REQ/DONE/ERR), default RESET_PC, TIMER_W=8 constant.
- One natural sub-module: fetch_timer. Loadable up-counter with clear, enable and a terminal flag at TIMEOUT.
- PC register and FSM stay in the top module.

Test Plan:
- Reset then fetch_en=1 at cycle 0, ack at cycle 1 with rdata=0x2408_0005 → imem_addr=0x3000 at cycle 1, ir_wr=1 and ir_data=0x2408_0005 at cycle 2, pc_out=0x3004.
- Ack delayed 5 cycles → imem_req stays high and imem_addr=0x3000 stable throughout; single ir_wr pulse; busy high from cycle 1 through DONE.
- pc_ld=1 with pc_ld_val=0x0000_4003 during REQ, ack later → no ir_wr, pc_out=0x4000, back in IDLE; next fetch addresses 0x4000.
- No ack for 15 cycles → imem_req drops, fetch_err=1, busy=1; subsequent fetch_en and late ack have no effect until rst.
- pc_ld to 0xFFFF_FFFC, fetch with ack → pc_out=0x0000_0000 after DONE.
- Assert rst while imem_req=1 → imem_req, ir_wr, ir_data zero immediately; pc_out=0x3000.
